// File: rtl/seg7_pkg.sv
// Shared constants for the front-panel helper.
//   SEG7_HEX : 7-segment codes for 0..F, bit order a..g in [6:0], active-high.
//   SEG_A..SEG_G : bit index of each segment within a seg vector.
package seg7_pkg;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/pb_debouncer.sv
// Pushbutton debouncer: synchronizes a raw button level, then only accepts a
// new level after it has differed from the stable state for 2^CNT_WIDTH
// consecutive cycles. Emits one-cycle press/release pulses on each change.
// Ports:
//   CLK      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   pb       raw button level, asynchronous to CLK
//   pb_state debounced level (1 = pressed)
//   pb_down  one-cycle pulse on pb_state 0->1
//   pb_up    one-cycle pulse on pb_state 1->0
module pb_debouncer #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic pb,
  output logic pb_state,
  output logic pb_down,
  output logic pb_up
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   state_q, state_d;
  logic                   down_q, down_d;
  logic                   up_q, up_d;
  logic                   pb_sync;
  logic                   idle;
  logic                   flip;

  assign pb_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pb};
    idle    = (state_q == pb_sync);
    // Count completes on the edge where a full 2^CNT_WIDTH disagreeing cycles
    // have been seen; the counter then wraps to 0 naturally.
    flip    = !idle && (cnt_q == {CNT_WIDTH{1'b1}});
    cnt_d   = idle ? '0 : cnt_q + CNT_WIDTH'(1);
    state_d = flip ? !state_q : state_q;
    down_d  = flip && !state_q;
    up_d    = flip && state_q;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      down_q  <= down_d;
      up_q    <= up_d;
    end
  end

  assign pb_state = state_q;
  assign pb_down  = down_q;
  assign pb_up    = up_q;

endmodule

// File: rtl/button_debounce_seg7.sv
// Front-panel helper: button debouncer plus combinational hex 7-segment decoder.
// Ports:
//   CLK, rst_n  shared clock and asynchronous active-low reset
//   pb          raw button level (active-high)
//   pb_state    debounced level; pb_down / pb_up one-cycle edge pulses
//   digit       value to display, 0..15
//   seg         active-high segment drive, seg[6]=a .. seg[0]=g (unaffected by reset)
module button_debounce_seg7
  import seg7_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       pb,
  output logic       pb_state,
  output logic       pb_down,
  output logic       pb_up,
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  pb_debouncer #(
    .CNT_WIDTH   (CNT_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_debouncer (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .pb       (pb),
    .pb_state (pb_state),
    .pb_down  (pb_down),
    .pb_up    (pb_up)
  );

  // Full 16-entry table, so every digit has a defined code.
  always_comb begin
    seg = SEG7_HEX[digit];
  end

endmodule

// File: tb/tb_button_debounce_seg7.sv
module tb_button_debounce_seg7;

  localparam int unsigned CW = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned LAT = SS + (1 << CW);  // 18 edges from first sampling

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       pb = 1'b0;
  logic       pb_state, pb_down, pb_up;
  logic [3:0] digit = 4'd0;
  logic [6:0] seg;

  int n_tests = 0;
  int n_fail  = 0;
  int n_down  = 0;
  int n_up    = 0;
  int n_bad   = 0;
  logic prev_pulse = 1'b0;

  button_debounce_seg7 #(
    .CNT_WIDTH   (CW),
    .SYNC_STAGES (SS)
  ) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .pb       (pb),
    .pb_state (pb_state),
    .pb_down  (pb_down),
    .pb_up    (pb_up),
    .digit    (digit),
    .seg      (seg)
  );

  always #5 CLK = ~CLK;

  // Pulse bookkeeping on the falling edge: counts pulses and flags overlap or
  // back-to-back pulses.
  always @(negedge CLK) begin
    if (pb_down) n_down++;
    if (pb_up) n_up++;
    if (pb_down && pb_up) n_bad++;
    if ((pb_down || pb_up) && prev_pulse) n_bad++;
    prev_pulse = pb_down || pb_up;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  logic [6:0] exp_seg [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  int d0, u0;

  initial begin
    // Reset with button held
    pb    = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check_eq("rst_state", 32'(pb_state), 0);
    check_eq("rst_down", 32'(pb_down), 0);
    check_eq("rst_up", 32'(pb_up), 0);
    rst_n = 1'b1;
    d0 = n_down;
    tick(LAT - 1);
    check_eq("press_before", 32'(pb_state), 0);
    tick(1);
    check_eq("press_state", 32'(pb_state), 1);
    check_eq("press_down_pulse", 32'(pb_down), 1);
    tick(1);
    check_eq("press_down_end", 32'(pb_down), 0);
    check_eq("press_down_cnt", 32'(n_down - d0), 1);

    // Release
    pb = 1'b0;
    u0 = n_up;
    tick(LAT - 1);
    check_eq("rel_before", 32'(pb_state), 1);
    tick(1);
    check_eq("rel_state", 32'(pb_state), 0);
    check_eq("rel_up_pulse", 32'(pb_up), 1);
    tick(2);
    check_eq("rel_up_cnt", 32'(n_up - u0), 1);

    // Bounce: toggle every 5 cycles for 100 cycles, then hold pressed
    d0 = n_down;
    for (int s = 0; s < 20; s++) begin
      pb = (s % 2 == 0);
      tick(5);
      check_eq("bounce_state", 32'(pb_state), 0);
    end
    pb = 1'b1;
    tick(LAT - 1);
    check_eq("bounce_before", 32'(pb_state), 0);
    tick(1);
    check_eq("bounce_rise", 32'(pb_state), 1);
    tick(2);
    check_eq("bounce_down_cnt", 32'(n_down - d0), 1);

    // Release from pressed
    d0 = n_down;
    u0 = n_up;
    pb = 1'b0;
    tick(LAT);
    check_eq("rel2_state", 32'(pb_state), 0);
    tick(2);
    check_eq("rel2_up_cnt", 32'(n_up - u0), 1);
    check_eq("rel2_down_cnt", 32'(n_down - d0), 0);

    // Glitches: 1-cycle and 15-cycle pulses never reach the output
    d0 = n_down;
    pb = 1'b1;
    tick(1);
    pb = 1'b0;
    tick(30);
    check_eq("glitch1_state", 32'(pb_state), 0);
    pb = 1'b1;
    tick(15);
    pb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_eq("glitch15_state", 32'(pb_state), 0);
    end
    check_eq("glitch_cnt_zero", 32'(dut.u_debouncer.cnt_q), 0);
    check_eq("glitch_down_cnt", 32'(n_down - d0), 0);

    // Reset mid-count
    pb = 1'b1;
    tick(10);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_state", 32'(pb_state), 0);
    check_eq("midrst_cnt", 32'(dut.u_debouncer.cnt_q), 0);
    tick(2);
    rst_n = 1'b1;
    tick(LAT - 1);
    check_eq("midrst_before", 32'(pb_state), 0);
    tick(1);
    check_eq("midrst_rise", 32'(pb_state), 1);
    pb = 1'b0;
    tick(LAT + 2);
    check_eq("midrst_release", 32'(pb_state), 0);

    check_eq("pulse_rules", 32'(n_bad), 0);

    // Decoder sweep (combinational)
    for (int d = 0; d < 16; d++) begin
      digit = 4'(d);
      #1;
      check_eq($sformatf("seg_%0h", d), 32'(seg), 32'(exp_seg[d]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
